// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- decode-side hazard bus between the ID stage and hazard_ctrl.
//
// Parameter: CNT_W  width of the stall counter (must match the controller).
// Signals (master = decode stage / driver, slave = hazard_ctrl):
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr, id_is_load,
//   redirect, clr_stats                      : master -> slave
//   stall, flush, fwd_a, fwd_b, stall_cnt    : slave  -> master
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       id_dst;
  logic             id_wr;
  logic             id_is_load;
  logic             redirect;
  logic             clr_stats;
  logic             stall;
  logic             flush;
  logic [2:0]       fwd_a;
  logic [2:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr,
           id_is_load, redirect, clr_stats,
    input  stall, flush, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr,
           id_is_load, redirect, clr_stats,
    output stall, flush, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- scoreboard-based hazard controller beside the decode stage.
//
// Tracks every in-flight register write in a DEPTH-entry destination
// scoreboard (entry 1 = EX ... entry DEPTH = WB) and derives per-operand
// forwarding selects, load-use stalls, redirect flushes and a saturating
// stall-cycle counter.
//
// Parameters:
//   DEPTH    stages after decode holding an unwritten result (1..4)
//   LOAD_LAT load data forwardable only from stage index > LOAD_LAT
//   CNT_W    stall counter width
// Ports:
//   clk  core clock, rst synchronous active-high reset
//   bus  hazard_ctrl_if.slave (decode inputs, stall/flush/fwd/stall_cnt out)
// Build option:
//   HAZARD_FWD_EN  defined   -> forwarding enabled, only load-use stalls
//                  undefined -> no forwarding, any in-flight match stalls
module hazard_ctrl #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Scoreboard entries, index 1 = youngest (EX).
  logic       v_q   [1:DEPTH];
  logic [4:0] dst_q [1:DEPTH];
  logic       ld_q  [1:DEPTH];
  logic       v_d   [1:DEPTH];
  logic [4:0] dst_d [1:DEPTH];
  logic       ld_d  [1:DEPTH];

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic       stall_c;
  logic       enter_c;
  logic [4:0] src   [2];
  logic       use_s [2];

  assign src[0]   = bus.id_rs;
  assign src[1]   = bus.id_rt;
  assign use_s[0] = bus.id_use_rs;
  assign use_s[1] = bus.id_use_rt;

  // Per-operand lookup: the youngest matching writer wins, so the search
  // runs oldest-to-youngest and the last hit overwrites earlier ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic       found;
    logic       ld_early;
    logic [2:0] hit;
    logic       hz;
    logic [2:0] fwd;

    always_comb begin
      found    = 1'b0;
      ld_early = 1'b0;
      hit      = 3'd0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (v_q[k] && dst_q[k] == src[gi]) begin
          found    = 1'b1;
          hit      = 3'(k);
          ld_early = ld_q[k] && (k <= LOAD_LAT);
        end
      end
      // $0 is never looked up, and unused operands never match.
      if (!use_s[gi] || src[gi] == 5'd0) begin
        found = 1'b0;
      end
      // Without forwarding every match is a hazard; with it only a load
      // whose data is not yet available stalls.
      hz  = found && (!FWD_EN || ld_early);
      fwd = (FWD_EN && found && !ld_early) ? hit : 3'd0;
    end
  end

  assign stall_c = bus.id_valid && !bus.redirect && (g_op[0].hz || g_op[1].hz);
  // A stalled or flushed ID instruction enters as a bubble.
  assign enter_c = bus.id_valid && bus.id_wr && (bus.id_dst != 5'd0) &&
                   !stall_c && !bus.redirect;

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 1) begin
        v_d[k]   = enter_c;
        dst_d[k] = enter_c ? bus.id_dst : 5'd0;
        ld_d[k]  = enter_c && bus.id_is_load;
      end else begin
        v_d[k]   = v_q[k-1];
        dst_d[k] = dst_q[k-1];
        ld_d[k]  = ld_q[k-1];
      end
    end
  end

  // Clear beats increment; the count sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.clr_stats) begin
      stall_cnt_d = '0;
    end else if (stall_c && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]   <= 1'b0;
        dst_q[k] <= 5'd0;
        ld_q[k]  <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_q[k]   <= v_d[k];
        dst_q[k] <= dst_d[k];
        ld_q[k]  <= ld_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flush     = bus.redirect;
  assign bus.fwd_a     = g_op[0].fwd;
  assign bus.fwd_b     = g_op[1].fwd;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the MIPS150 core, sitting beside the decode stage. It replaces fixed one-stage-back forwarding with a DEPTH-entry destination scoreboard that tracks every in-flight register write. From that scoreboard it produces per-operand forwarding selects, load-use stalls, redirect flushes and a saturating stall-cycle counter.

## Interface
- DEPTH, 2, pipeline stages after decode that hold an unwritten result (EX = 1 … WB = DEPTH); legal 1..4.
- LOAD_LAT, 1, load data is forwardable only from stage index > LOAD_LAT; legal 0..DEPTH-1.
- CNT_W, 16, stall counter width.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs, id_rt  in  5  source register numbers.
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt.
- id_dst  in  5  destination register (rd for R-type, rt for I-type/loads, 31 for JAL).
- id_wr  in  1  instruction writes id_dst.
- id_is_load  in  1  instruction is LB/LH/LW/LBU/LHU.
- redirect  in  1  taken branch/jump resolved in EX this cycle.
- clr_stats  in  1  clear stall counter.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  kill the instruction in ID.
- fwd_a, fwd_b  out  3  0 = register file, k = result of stage k.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Scoreboard: entries 1..DEPTH, each {v, dst[4:0], ld}. Each posedge: entry[k] <= entry[k-1] for k ≥ 2; entry[1] <= {1, id_dst, id_is_load} when id_valid & id_wr & id_dst≠0 & !stall & !redirect, else all-zero (bubble).
- Match for source s (rs with id_use_rs, rt with id_use_rt; s≠0): smallest k with entry[k].v & entry[k].dst==s. The youngest writer always wins.
- With forwarding enabled: no match -> fwd=0. Match with entry[k].ld and k ≤ LOAD_LAT -> hazard. Otherwise fwd=k.
- stall = id_valid & !redirect & (hazard on rs | hazard on rt).
- flush = redirect. redirect overrides stall. The ID instruction is not entered into the scoreboard.
- fwd_a/fwd_b are driven from match logic even while stalled. The consumer ignores them on bubbles.
- Register $0 never matches: it is never entered and never looked up.
- stall_cnt: +1 on each cycle with stall=1; holds at 2^CNT_W-1. Cleared by clr_stats. If clr_stats and stall occur together, clear wins (result 0).
- Register file is not write-through. A result leaving stage DEPTH is readable from the register file the next cycle.

## Timing
- stall, flush, fwd_a, fwd_b: combinational, same cycle as ID inputs and scoreboard state. No added latency.
- Scoreboard and counter: one-cycle update on posedge clk.
- Reset (rst=1 at posedge): all entries v=0, stall_cnt=0. After reset with id_valid=0: stall=0, flush=redirect, fwd_a=fwd_b=0.
- Reset mid-operation discards all in-flight entries, so no forward or stall references pre-reset instructions.
- Load-use with LOAD_LAT=1: exactly 1 stall cycle, then fwd=2.
- Simultaneous redirect and hazard: stall=0, flush=1, bubble enters entry[1].

## Configuration
- HAZARD_FWD_EN defined: forwarding as above. Only load-use hazards stall.
- Not defined: fwd_a=fwd_b=0 always. Any match is a hazard, so the pipe stalls until the producer has left stage DEPTH. Counter and flush behaviour are unchanged.

## Test plan
- DEPTH=2, fwd on: ADD $3 then ADD $4,$3,$3 -> fwd_a=fwd_b=1, stall=0. Same use 2 instrs later -> fwd=2. 3 later -> fwd=0.
- LW $5 then ADDU $6,$5,$0 -> stall=1 for 1 cycle, stall_cnt=1, then fwd_a=2, fwd_b=0.
- ADD $3 then ADD $3 then use $3 -> fwd_a=1 (youngest). ADDU $0 then use $0 -> fwd=0, stall=0.
- LW $5 in EX with redirect=1 and a dependent instruction in ID -> stall=0, flush=1. Next cycle entry[1].v=0.
- HAZARD_FWD_EN undefined, DEPTH=2: ADD $3 then use $3 -> stall 2 cycles, fwd=0 throughout, stall_cnt=2.
- CNT_W=4: force 20 stall cycles -> stall_cnt holds 15. clr_stats with stall=1 -> 0. rst mid-hazard -> stall=0 next cycle.
